// File: rtl/mavg_channel_scheduler_if.sv
// Handshake bundle between the per-channel sample front ends, the shared averager and the consumer.
interface mavg_channel_scheduler_if #(
   parameter int NUM_CH       = 4,
   parameter int CH_BITS      = 2,
   parameter int DATA_W       = 16,
   parameter int AVE_DATA_BIT = 3
);
   logic [NUM_CH-1:0]              in_valid;
   logic [NUM_CH*DATA_W-1:0]       in_data;
   logic [NUM_CH-1:0]              in_ready;
   logic                           clear;
   logic                           out_valid;
   logic                           out_ready;
   logic [DATA_W-1:0]              out_data;
   logic [DATA_W+AVE_DATA_BIT-1:0] out_sum;
   logic [CH_BITS-1:0]             out_ch;
   logic                           busy;

   modport master (
      output in_valid, in_data, clear, out_ready,
      input  in_ready, out_valid, out_data, out_sum, out_ch, busy
   );

   modport slave (
      input  in_valid, in_data, clear, out_ready,
      output in_ready, out_valid, out_data, out_sum, out_ch, busy
   );
endinterface

// File: rtl/mavg_channel_scheduler.sv
// Round-robin scheduler sharing one running-sum moving-average datapath among NUM_CH channels.
// Each channel keeps its own history window, running sum and write pointer.
module mavg_channel_scheduler #(
   parameter int NUM_CH       = 4,
   parameter int CH_BITS      = 2,
   parameter int DATA_W       = 16,
   parameter int AVE_DATA_BIT = 3,
   parameter int AVE_DATA_NUM = 8
) (
   input logic                     clk,
   input logic                     reset,
   mavg_channel_scheduler_if.slave bus
);
   localparam int SUM_W = DATA_W + AVE_DATA_BIT;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [DATA_W-1:0]       hist_r [NUM_CH][AVE_DATA_NUM];
   logic [SUM_W-1:0]        sum_r  [NUM_CH];
   logic [AVE_DATA_BIT-1:0] wptr_r [NUM_CH];
   logic [CH_BITS-1:0]      last_grant_r;
   logic [CH_BITS-1:0]      gch_r;
   logic [DATA_W-1:0]       smp_r;
   logic                    clear_pend_r;
   logic                    out_valid_r;
   logic [DATA_W-1:0]       out_data_r;
   logic [SUM_W-1:0]        out_sum_r;
   logic [CH_BITS-1:0]      out_ch_r;
   logic                    busy_r;

   logic [CH_BITS-1:0]      pick_s;
   logic                    pick_ok_s;
   logic                    grant_s;
   logic                    do_clear_s;
   logic [NUM_CH-1:0]       in_ready_s;
   logic [SUM_W-1:0]        new_sum_s;

   // First requester after 'last' in circular order; MSB flags that one was found.
   function automatic logic [CH_BITS:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CH_BITS-1:0] last);
      logic [CH_BITS:0] res;
      int               idx;
      res = '0;
      for (int i = NUM_CH; i >= 1; i--) begin
         idx = (int'(last) + i) % NUM_CH;
         if (req[CH_BITS'(idx)]) begin
            res = {1'b1, CH_BITS'(idx)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Intermediate sum may wrap, but the oldest sample is already inside sum_r so the result fits.
   assign new_sum_s = sum_r[gch_r] + SUM_W'(smp_r) - SUM_W'(hist_r[gch_r][wptr_r[gch_r]]);

   // Next-state, grant and clear decode.
   always_comb begin
      state_nxt_s         = state_r;
      in_ready_s          = '0;
      do_clear_s          = 1'b0;
      grant_s             = 1'b0;
      {pick_ok_s, pick_s} = rr_pick(bus.in_valid, last_grant_r);
      case (state_r)
         IDLE: begin
            if (bus.clear || clear_pend_r) begin
               do_clear_s  = 1'b1;
               state_nxt_s = IDLE;
            end else if (pick_ok_s) begin
               grant_s            = 1'b1;
               in_ready_s[pick_s] = 1'b1;
               state_nxt_s        = CALC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CALC: begin
            state_nxt_s = OUT;
         end
         OUT: begin
            if (bus.out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = OUT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Per-channel history, running sum and write pointer; clear wipes all channels at once.
   always_ff @(posedge clk) begin
      if (reset || do_clear_s) begin
         for (int c = 0; c < NUM_CH; c++) begin
            for (int w = 0; w < AVE_DATA_NUM; w++) begin
               hist_r[c][w] <= '0;
            end
            sum_r[c]  <= '0;
            wptr_r[c] <= '0;
         end
      end else if (state_r == CALC) begin
         hist_r[gch_r][wptr_r[gch_r]] <= smp_r;
         sum_r[gch_r]                 <= new_sum_s;
         wptr_r[gch_r]                <= wptr_r[gch_r] + AVE_DATA_BIT'(1);
      end
   end

   // Grant capture, pending clear and registered result.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_r <= CH_BITS'(NUM_CH - 1);
         gch_r        <= '0;
         smp_r        <= '0;
         clear_pend_r <= 1'b0;
         out_valid_r  <= 1'b0;
         out_data_r   <= '0;
         out_sum_r    <= '0;
         out_ch_r     <= '0;
         busy_r       <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s != IDLE);
         if (do_clear_s) begin
            clear_pend_r <= 1'b0;
         end else if (bus.clear) begin
            clear_pend_r <= 1'b1;
         end
         if (grant_s) begin
            smp_r        <= bus.in_data[pick_s*DATA_W +: DATA_W];
            gch_r        <= pick_s;
            last_grant_r <= pick_s;
         end
         if (state_r == CALC) begin
            out_sum_r   <= new_sum_s;
            out_data_r  <= new_sum_s[SUM_W-1:AVE_DATA_BIT];
            out_ch_r    <= gch_r;
            out_valid_r <= 1'b1;
         end else if ((state_r == OUT) && bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_sum   = out_sum_r;
   assign bus.out_ch    = out_ch_r;
   assign bus.busy      = busy_r;

endmodule
